// File: rtl/uart_tx_if.sv
// Bundle between a UART transmitter and its driver.
// Carries the baud tick, frame request/config and the serial line status.
interface uart_tx_if;
    logic       tick;
    logic       TxStart;
    logic [7:0] TxData;
    logic [3:0] NBits;
    logic       ParityEn;
    logic       ParityOdd;
    logic       TwoStop;
    logic       Tx;
    logic       TxBusy;
    logic       TxDone;

    modport master (
        output tick, TxStart, TxData, NBits,
        output ParityEn, ParityOdd, TwoStop,
        input  Tx, TxBusy, TxDone
    );

    modport slave (
        input  tick, TxStart, TxData, NBits,
        input  ParityEn, ParityOdd, TwoStop,
        output Tx, TxBusy, TxDone
    );
endinterface

// File: rtl/uart_tx.sv
// Configurable UART transmitter: 5-8 data bits, optional parity,
// one or two stop bits, 16 ticks per bit cell.
module uart_tx (
    input  logic      clk,
    input  logic      Rst_n,
    uart_tx_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t     state, state_d;
    logic [3:0] tick_cnt, tick_cnt_d;
    logic [2:0] bit_idx, bit_idx_d;
    logic [2:0] idx_inc;
    logic       stop_cnt, stop_cnt_d;
    logic [7:0] data_q, data_d;
    logic [3:0] nbits_q, nbits_d;
    logic       par_en_q, par_en_d;
    logic       par_odd_q, par_odd_d;
    logic       two_stop_q, two_stop_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       cell_end;
    logic       last_bit;
    logic [3:0] nb_clamp;
    logic [7:0] nb_mask;

    always_comb begin
        nb_clamp = bus.NBits;
        if (bus.NBits < 4'd5) begin
            nb_clamp = 4'd5;
        end else if (bus.NBits > 4'd8) begin
            nb_clamp = 4'd8;
        end
        // Bits above N are cleared at load so parity can XOR all 8.
        nb_mask = ~(8'hFF << nb_clamp);
    end

    assign cell_end = bus.tick && (tick_cnt == 4'hF);
    assign last_bit = ({1'b0, bit_idx} == (nbits_q - 4'd1));
    assign idx_inc  = bit_idx + 3'd1;

    always_comb begin
        state_d    = state;
        tick_cnt_d = bus.tick ? tick_cnt + 4'd1 : tick_cnt;
        bit_idx_d  = bit_idx;
        stop_cnt_d = stop_cnt;
        data_d     = data_q;
        nbits_d    = nbits_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        two_stop_d = two_stop_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        unique case (state)
            IDLE: begin
                tick_cnt_d = 4'd0;
                tx_d       = 1'b1;
                busy_d     = 1'b0;
                if (bus.TxStart) begin
                    state_d    = START;
                    data_d     = bus.TxData & nb_mask;
                    nbits_d    = nb_clamp;
                    par_en_d   = bus.ParityEn;
                    par_odd_d  = bus.ParityOdd;
                    two_stop_d = bus.TwoStop;
                    bit_idx_d  = 3'd0;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            START: begin
                if (cell_end) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = data_q[0];
                end
            end
            DATA: begin
                if (cell_end) begin
                    if (last_bit) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = (^data_q) ^ par_odd_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = idx_inc;
                        tx_d      = data_q[idx_inc];
                    end
                end
            end
            PARITY: begin
                if (cell_end) begin
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end
            STOP: begin
                if (cell_end) begin
                    if (two_stop_q && !stop_cnt) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        stop_cnt_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            state      <= IDLE;
            tick_cnt   <= 4'd0;
            bit_idx    <= 3'd0;
            stop_cnt   <= 1'b0;
            data_q     <= 8'd0;
            nbits_q    <= 4'd0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_d;
            tick_cnt   <= tick_cnt_d;
            bit_idx    <= bit_idx_d;
            stop_cnt   <= stop_cnt_d;
            data_q     <= data_d;
            nbits_q    <= nbits_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.Tx     = tx_q;
    assign bus.TxBusy = busy_q;
    assign bus.TxDone = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame model feeds a scoreboard that a
// tick-counting line monitor checks bit by bit.
module tb_uart_tx;

    typedef struct {
        logic [11:0] bits;
        int          len;
    } frm_t;

    logic clk = 1'b0;
    logic Rst_n;
    bit   tick_en = 1'b0;
    int   div = 0;
    int   checks = 0;
    int   errors = 0;
    frm_t sb[$];

    uart_tx_if bus();

    uart_tx dut (
        .clk  (clk),
        .Rst_n(Rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Tick every second clock, changed just after the rising edge.
    initial begin
        bus.tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            div++;
            bus.tick = tick_en && (div % 2 == 1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic frm_t model(input logic [7:0] d, input logic [3:0] nb,
                                   input logic pe, input logic po,
                                   input logic ts);
        frm_t f;
        int   n;
        int   k;
        logic p;
        n = (nb < 5) ? 5 : ((nb > 8) ? 8 : int'(nb));
        f.bits = '0;
        f.bits[0] = 1'b0;
        k = 1;
        p = 1'b0;
        for (int i = 0; i < n; i++) begin
            f.bits[k] = d[i];
            p = p ^ d[i];
            k++;
        end
        if (pe) begin
            f.bits[k] = p ^ po;
            k++;
        end
        f.bits[k] = 1'b1;
        k++;
        if (ts) begin
            f.bits[k] = 1'b1;
            k++;
        end
        f.len = k;
        return f;
    endfunction

    task automatic set_cfg(input logic [7:0] d, input logic [3:0] nb,
                           input logic pe, input logic po, input logic ts);
        bus.TxData    = d;
        bus.NBits     = nb;
        bus.ParityEn  = pe;
        bus.ParityOdd = po;
        bus.TwoStop   = ts;
    endtask

    task automatic start_frame(input logic [7:0] d, input logic [3:0] nb,
                               input logic pe, input logic po,
                               input logic ts, input bit push = 1'b1);
        @(posedge clk);
        #1;
        set_cfg(d, nb, pe, po, ts);
        bus.TxStart = 1'b1;
        if (push) sb.push_back(model(d, nb, pe, po, ts));
        @(posedge clk);
        #1;
        bus.TxStart = 1'b0;
    endtask

    task automatic mon_frame(input string tag, output int waited);
        frm_t e;
        int   n;
        int   last;
        int   guard;
        bit   early;
        bit   busy_bad;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus.TxBusy !== 1'b1 && waited < 100);
        chk({tag, "_sb"}, 32'(sb.size() != 0), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk({tag, "_busy0"}, bus.TxBusy, 1);
        chk({tag, "_start"}, bus.Tx, 0);
        n = 0;
        last = -1;
        guard = 0;
        early = 1'b0;
        busy_bad = 1'b0;
        while (n < e.len * 16 && guard < 5000) begin
            if (bus.TxDone) early = 1'b1;
            if (!bus.TxBusy) busy_bad = 1'b1;
            if (n % 16 == 8 && n / 16 != last) begin
                last = n / 16;
                chk($sformatf("%s_cell%0d", tag, last), bus.Tx,
                    e.bits[last]);
            end
            if (bus.tick) n++;
            @(negedge clk);
            guard++;
        end
        chk({tag, "_len"}, n, e.len * 16);
        chk({tag, "_done"}, bus.TxDone, 1);
        chk({tag, "_busyend"}, bus.TxBusy, 0);
        chk({tag, "_idle"}, bus.Tx, 1);
        chk({tag, "_early"}, early, 0);
        chk({tag, "_busyhole"}, busy_bad, 0);
    endtask

    task automatic quiet(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.TxBusy || bus.TxDone || !bus.Tx) seen = 1'b1;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        int w;
        int n;
        int g;
        logic [7:0] vals [3];
        Rst_n = 1'b0;
        bus.TxStart = 1'b0;
        set_cfg(8'h00, 4'd8, 1'b0, 1'b0, 1'b0);
        tick_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", bus.Tx, 1);
        chk("rst_busy", bus.TxBusy, 0);
        chk("rst_done", bus.TxDone, 0);
        Rst_n = 1'b1;

        start_frame(8'h55, 4'd8, 1'b0, 1'b0, 1'b0);
        mon_frame("f55", w);
        start_frame(8'hA3, 4'd8, 1'b1, 1'b0, 1'b1);
        mon_frame("fA3", w);
        start_frame(8'h1F, 4'd5, 1'b1, 1'b1, 1'b0);
        mon_frame("f1F_n5", w);
        start_frame(8'h1F, 4'd2, 1'b1, 1'b1, 1'b0);
        mon_frame("f1F_n2", w);
        start_frame(8'hE3, 4'd5, 1'b1, 1'b0, 1'b1);
        mon_frame("fE3_mask", w);
        start_frame(8'h96, 4'd12, 1'b1, 1'b1, 1'b0);
        mon_frame("f96_n12", w);

        // Request while busy must be dropped, not queued.
        start_frame(8'h3C, 4'd7, 1'b0, 1'b0, 1'b0);
        fork
            mon_frame("fbusy", w);
            begin
                repeat (60) @(negedge clk);
                bus.TxData = 8'hFF;
                bus.TxStart = 1'b1;
                @(negedge clk);
                bus.TxStart = 1'b0;
            end
        join
        quiet("busy_ignored", 40);

        // Held request: three back-to-back frames, inputs scrambled mid-frame.
        vals[0] = 8'h11;
        vals[1] = 8'hC4;
        vals[2] = 8'h7E;
        @(posedge clk);
        #1;
        set_cfg(vals[0], 4'd8, 1'b0, 1'b0, 1'b0);
        bus.TxStart = 1'b1;
        sb.push_back(model(vals[0], 4'd8, 1'b0, 1'b0, 1'b0));
        fork
            begin
                mon_frame("b2b0", w);
                mon_frame("b2b1", w);
                chk("b2b1_gap", w, 1);
                mon_frame("b2b2", w);
                chk("b2b2_gap", w, 1);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    g = 0;
                    do begin
                        @(negedge clk);
                        g++;
                    end while (!bus.TxBusy && g < 100);
                    repeat (30) @(negedge clk);
                    set_cfg(8'hFF, 4'd5, 1'b1, 1'b1, 1'b1);
                    g = 0;
                    do begin
                        @(negedge clk);
                        g++;
                    end while (!bus.TxDone && g < 2000);
                    if (k < 2) begin
                        set_cfg(vals[k+1], 4'd8, 1'b0, 1'b0, 1'b0);
                        sb.push_back(model(vals[k+1], 4'd8, 1'b0, 1'b0,
                                           1'b0));
                    end else begin
                        bus.TxStart = 1'b0;
                    end
                end
            end
        join
        quiet("b2b_stop", 40);

        // Reset while data bit 3 is on the line.
        start_frame(8'h5A, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        n = 0;
        g = 0;
        @(negedge clk);
        while (n < 72 && g < 1000) begin
            if (bus.tick) n++;
            @(negedge clk);
            g++;
        end
        chk("rst_mid_bit3", bus.Tx, 1);
        Rst_n = 1'b0;
        bus.TxStart = 1'b1;
        @(negedge clk);
        chk("rst_mid_tx", bus.Tx, 1);
        chk("rst_mid_busy", bus.TxBusy, 0);
        chk("rst_mid_done", bus.TxDone, 0);
        Rst_n = 1'b1;
        bus.TxStart = 1'b0;
        quiet("rst_no_done", 60);
        start_frame(8'h81, 4'd8, 1'b1, 1'b0, 1'b0);
        mon_frame("f81_post_rst", w);

        // Stall tick for 1000 clocks in data cell 3 (data bit 2 = 1).
        start_frame(8'hC6, 4'd8, 1'b0, 1'b0, 1'b0);
        fork
            mon_frame("fC6_freeze", w);
            begin
                repeat (110) @(negedge clk);
                tick_en = 1'b0;
                repeat (3) @(negedge clk);
                chk("freeze_pre", bus.Tx, 1);
                repeat (1000) @(negedge clk);
                chk("freeze_post", bus.Tx, 1);
                chk("freeze_busy", bus.TxBusy, 1);
                tick_en = 1'b1;
            end
        join

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 clk  input  1  system clock; all state changes on posedge clk.
REQ-002 Rst_n  input  1  reset, synchronous, active-low.
REQ-003 tick  input  1  baud enable at 16x bit rate, one clk wide; all bit timing counts ticks only.
REQ-004 TxStart  input  1  request to send; sampled on every clk edge.
REQ-005 TxData  input  8  frame payload; bit 0 is sent first.
REQ-006 NBits  input  4  data bits per frame; 0-4 treated as 5, 9-15 treated as 8.
REQ-007 ParityEn  input  1  1 = append a parity bit after the data bits.
REQ-008 ParityOdd  input  1  1 = odd parity, 0 = even parity; ignored when ParityEn=0.
REQ-009 TwoStop  input  1  1 = two stop bits, 0 = one stop bit.
REQ-010 Tx  output  1  serial line, registered, idle high.
REQ-011 TxBusy  output  1  registered; high while a frame is in progress.
REQ-012 TxDone  output  1  registered; one-clk pulse at frame end.

Function
REQ-013 States: IDLE, START, DATA, PARITY, STOP; no other encodings are reachable.
REQ-014 IDLE: Tx=1 and TxBusy=0; TxStart=1 on an edge moves the block to START, loads TxData, NBits (clamped), ParityEn, ParityOdd and TwoStop into internal registers, and clears the tick and bit counters.
REQ-015 Latency: Tx=0 and TxBusy=1 from the edge that accepts TxStart; a tick in the accept cycle is not counted.
REQ-016 Each bit cell lasts exactly 16 ticks, counted by a 4-bit counter; the cell ends on the edge where the counter is 15 and tick=1.
REQ-017 START: drive 0 for one cell, then go to DATA with bit index 0.
REQ-018 DATA: drive latched data[index]; at cell end, increment the index; after index N-1, go to PARITY if ParityEn, else to STOP.
REQ-019 PARITY: drive the XOR of latched data bits 0..N-1 (even), or its inverse (odd), for one cell, then go to STOP.
REQ-020 STOP: drive 1 for one cell (TwoStop=0) or two cells (TwoStop=1), then go to IDLE.
REQ-021 Frame length = 16*(1+N+P+S) ticks, where P = ParityEn and S = 1 + TwoStop.
REQ-022 On the edge that ends the last stop cell, the block enters IDLE, sets TxBusy=0, and sets TxDone=1 for exactly one clk.
REQ-023 TxStart while TxBusy=1 is ignored; it is not queued.
REQ-024 TxStart in the cycle TxDone=1 is accepted (back-to-back frames with no extra idle cell).
REQ-025 Changes to TxData or to any configuration input during a frame have no effect on the frame in progress.
REQ-026 Unused high bits of TxData are never transmitted.

Reset
REQ-027 Rst_n=0 at an edge: next values are state=IDLE, Tx=1, TxBusy=0, TxDone=0, and all counters and latched registers = 0; this holds in any state.
REQ-028 Reset during a frame aborts it without a TxDone pulse; TxStart is ignored while Rst_n=0.

Verification
REQ-029 TxData=0x55, N=8, no parity, 1 stop -> Tx sequence 0,1,0,1,0,1,0,1,0,1, 16 ticks per bit; TxDone after 160 ticks.
REQ-030 TxData=0xA3, N=8, even parity, 2 stop -> data 1,1,0,0,0,1,0,1, parity 0, stop 1,1; total 192 ticks.
REQ-031 TxData=0x1F, NBits=5, odd parity -> data 1,1,1,1,1, parity 0; NBits=2 behaves identically to NBits=5.
REQ-032 TxStart held high for 3 frames with TxData changing mid-frame -> three contiguous frames, each carrying the value sampled at its accept edge; TxBusy stays high except in each TxDone cycle.
REQ-033 Rst_n=0 for 1 clk at data bit 3 -> Tx=1 and TxBusy=0 on the next edge, no TxDone pulse; a new TxStart after reset starts a clean frame.
REQ-034 tick held low for 1000 clk mid-bit -> Tx holds its value and the counters freeze; the frame resumes correctly when tick restarts.
